ffd_sinc_bank: RTL and testbench
================================

# ffd_sinc_bank

Parametrised bank of N synchronous enable registers, each W bits wide, with a per-channel staging layer and an atomic commit. This is the next-generation replacement for the 3-bit single-channel enable flip-flop used in the time/date datapath. Software-facing writes land in staging one channel at a time; a single `commit` transfers every staged channel to the outputs on the same edge. Downstream blocks therefore never see a half-updated time/date set.

## Interface
- `W`, 8, data width per channel
- `N`, 4, channel count (1..16; need not be a power of two)
- `AW`, clog2(N) (min 1), address width
- `RESET_VAL`, 0, W-bit reset value of every staged and committed channel
- `WRITE_THROUGH`, 0, 1 = `q_flat` shows the committing value combinationally in the commit cycle
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write `wr_data` into staging channel `wr_addr`
- `wr_addr`  in  AW  staging channel index
- `wr_data`  in  W  staging write data
- `commit`  in  1  copy all dirty staging channels to committed outputs
- `discard`  in  1  reload staging from committed values, clear dirty mask
- `rd_addr`  in  AW  staging read index
- `rd_data`  out  W  staging[rd_addr], combinational from registers
- `q_flat`  out  N*W  committed values; channel i at bits [i*W +: W]
- `dirty`  out  N  per-channel "staged differs from last commit" flags
- `pending`  out  1  high in state DIRTY
- `commit_done`  out  1  one-cycle pulse after a commit that transferred ≥1 channel

## Operation
- Reset values: staging[i] = committed[i] = RESET_VAL; `dirty` = 0; `pending` = 0; `commit_done` = 0; state IDLE.
- FSM states:
  - IDLE: dirty mask zero.
  - DIRTY: any dirty bit set.
- FSM transitions:
  - IDLE→DIRTY on an accepted write.
  - DIRTY→IDLE on `commit` or `discard`.
  - DIRTY→DIRTY on a write alone.
- Write: staging[wr_addr] ← wr_data; dirty[wr_addr] ← 1, even if the data equals the committed value.
- Out-of-range `wr_addr` (≥ N): write ignored, no state change. Out-of-range `rd_addr`: `rd_data` = 0.
- Commit: committed[i] ← staging[i] for each dirty i; clean channels hold. Dirty mask cleared. `commit_done` pulses the next cycle only if the mask was nonzero.
- Commit while IDLE with no write: no-op, no pulse.
- Discard: staging[i] ← committed[i] for all i; mask cleared; no pulse.
- Write + commit in the same cycle: the write is merged; committed[wr_addr] takes `wr_data` and its dirty bit counts toward the pulse. Result is IDLE.
- Write + discard in the same cycle: discard wins and the write is dropped.
- Commit + discard in the same cycle: commit wins and discard is ignored. This applies with or without a write.
- `rd_data` reflects registered staging only; there is no bypass of a same-cycle write.

## Timing
- Write at edge k: `rd_data` and `dirty` update after k.
- Commit at edge k:
  - WRITE_THROUGH=0: `q_flat` updates after k.
  - WRITE_THROUGH=1: `q_flat` shows the merged next values combinationally during the commit cycle, before k.
  - `commit_done` is high for exactly the cycle after k.
- Back-to-back commits: the second one is a no-op unless a write intervened.
- Reset has priority over all inputs. Reset asserted mid-DIRTY or in the commit cycle: every register returns to its reset value at that edge, and no `commit_done` pulse follows.
- No combinational path from inputs to outputs except `rd_addr`→`rd_data`, and, with WRITE_THROUGH=1, wr_*/commit→`q_flat`.

## Structure
- Package `ffd_sinc_pkg`:
  - state encoding IDLE/DIRTY
  - clog2 function for AW
  - channel-slice helper macros/constants
- One sub-module, `ffd_sinc_chan`, per channel, generate-instantiated N times:
  - holds staging, committed and dirty registers
  - inputs: local write strobe, commit, discard
  - outputs: committed value and next-committed value
- Top level contains:
  - address decode and range check
  - FSM
  - `commit_done` flop
  - `rd_data` mux
  - WRITE_THROUGH output select

## Test plan
- Reset then idle (W=8, N=4, RESET_VAL=8'h00): `q_flat` = 0, `dirty` = 0, `pending` = 0, no `commit_done` for 10 cycles.
- Write ch1=8'h23, then ch3=8'h59 → `dirty`=4'b1010, `q_flat` unchanged. Commit → `q_flat`[15:8]=8'h23, [31:24]=8'h59 after the edge, one-cycle `commit_done`, `dirty`=0.
- Write ch0=8'h12 together with commit → committed ch0=8'h12 on the same edge, `pending` low afterwards. With WRITE_THROUGH=1, `q_flat`[7:0]=8'h12 during the commit cycle.
- Stage ch2=8'hAA, then discard → `rd_data`(rd_addr=2) returns the committed value, `dirty`=0, no pulse. Write+discard same cycle → write dropped.
- N=3: write to addr 3 → ignored, `rd_data`(3)=0. Commit in IDLE → no pulse.
- Reset asserted in the commit cycle → all channels RESET_VAL, `commit_done` stays 0.

Source files
------------

// File: rtl/ffd_sinc_pkg.sv
// Package shared by the staged enable-register bank.
// Contents:
//   state_e        - two-state controller encoding (IDLE / DIRTY)
//   ffd_sinc_clog2 - address width for a channel count, never below 1
//   chan_lsb       - lowest bit of a channel inside the flattened output bus
package ffd_sinc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DIRTY = 1'b1
    } state_e;

    // Width of an index able to address 'value' channels. A single
    // channel still gets a 1-bit address so port widths never collapse.
    function automatic int ffd_sinc_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Bit offset of channel 'chan' in a bus of 'width'-bit channels.
    function automatic int chan_lsb(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/ffd_sinc_chan.sv
// One channel of the staged enable-register bank.
// Holds the staging value, the committed value and the dirty flag.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   wr_stb      - write strobe for this channel (already decoded and gated)
//   wr_data     - data to stage
//   commit      - copy staging to committed if dirty (or merge wr_data)
//   discard     - reload staging from committed; ignored when commit is high
//   stage_val   - registered staging value
//   commit_val  - registered committed value
//   commit_nxt  - value committed_q will take at the next edge
//   dirty       - staged value not yet committed
module ffd_sinc_chan
    import ffd_sinc_pkg::*;
#(
    parameter int               W         = 8,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_stb,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    input  logic         discard,
    output logic [W-1:0] stage_val,
    output logic [W-1:0] commit_val,
    output logic [W-1:0] commit_nxt,
    output logic         dirty
);

    logic [W-1:0] stage_q, stage_d;
    logic [W-1:0] committed_q, committed_d;
    logic         dirty_q, dirty_d;

    // Commit has priority over discard. A write landing in the commit
    // cycle is merged straight into the committed value, so staging and
    // committed agree again afterwards.
    always_comb begin
        stage_d     = stage_q;
        committed_d = committed_q;
        dirty_d     = dirty_q;
        if (commit) begin
            if (wr_stb) begin
                stage_d     = wr_data;
                committed_d = wr_data;
            end else if (dirty_q) begin
                committed_d = stage_q;
            end
            dirty_d = 1'b0;
        end else if (discard) begin
            stage_d = committed_q;
            dirty_d = 1'b0;
        end else if (wr_stb) begin
            stage_d = wr_data;
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= RESET_VAL;
            committed_q <= RESET_VAL;
            dirty_q     <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            committed_q <= committed_d;
            dirty_q     <= dirty_d;
        end
    end

    assign stage_val  = stage_q;
    assign commit_val = committed_q;
    assign commit_nxt = committed_d;
    assign dirty      = dirty_q;

endmodule

// File: rtl/ffd_sinc_bank.sv
// Bank of N W-bit enable registers with per-channel staging and an
// atomic commit: writes land in staging one channel at a time, and a
// single commit moves every dirty channel to q_flat on the same edge.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   wr_en        - stage wr_data into channel wr_addr (ignored if wr_addr >= N)
//   wr_addr      - staging write index
//   wr_data      - staging write data
//   commit       - transfer dirty staging channels to q_flat
//   discard      - reload staging from committed values (commit wins)
//   rd_addr      - staging read index
//   rd_data      - staging[rd_addr], zero when out of range
//   q_flat       - committed values, channel i at [i*W +: W]
//   dirty        - per-channel uncommitted flags
//   pending      - high while any channel is dirty
//   commit_done  - one-cycle pulse after a commit that moved data
module ffd_sinc_bank
    import ffd_sinc_pkg::*;
#(
    parameter int           W             = 8,
    parameter int           N             = 4,
    parameter int           AW            = ffd_sinc_clog2(N),
    parameter logic [W-1:0] RESET_VAL     = '0,
    parameter bit           WRITE_THROUGH = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           commit,
    input  logic           discard,
    input  logic [AW-1:0]  rd_addr,
    output logic [W-1:0]   rd_data,
    output logic [N*W-1:0] q_flat,
    output logic [N-1:0]   dirty,
    output logic           pending,
    output logic           commit_done
);

    logic         wr_in_range;
    logic         wr_accept;
    logic [N-1:0] wr_stb;
    logic [W-1:0] stage_val  [N];
    logic [W-1:0] commit_val [N];
    logic [W-1:0] commit_nxt [N];

    state_e state_q, state_d;
    logic   commit_done_q, commit_done_d;

    // A write is dropped when a discard (without commit) shares its cycle.
    assign wr_in_range = (int'(wr_addr) < N);
    assign wr_accept   = wr_en && wr_in_range && !(discard && !commit);

    always_comb begin
        wr_stb = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_accept && (int'(wr_addr) == i)) begin
                wr_stb[i] = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_chan
            ffd_sinc_chan #(
                .W         (W),
                .RESET_VAL (RESET_VAL)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .wr_stb     (wr_stb[g]),
                .wr_data    (wr_data),
                .commit     (commit),
                .discard    (discard),
                .stage_val  (stage_val[g]),
                .commit_val (commit_val[g]),
                .commit_nxt (commit_nxt[g]),
                .dirty      (dirty[g])
            );

            // Write-through exposes the merged next value during the
            // commit cycle; outside a commit both choices are identical.
            if (WRITE_THROUGH) begin : g_wt
                assign q_flat[chan_lsb(g, W) +: W] = commit_nxt[g];
            end else begin : g_reg
                assign q_flat[chan_lsb(g, W) +: W] = commit_val[g];
            end
        end
    endgenerate

    // Controller: DIRTY while anything is staged but not committed.
    always_comb begin
        state_d       = state_q;
        commit_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!commit && !discard && wr_accept) begin
                    state_d = DIRTY;
                end
            end
            DIRTY: begin
                if (commit || discard) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A merged same-cycle write counts as moved data.
        commit_done_d = commit && ((|dirty) || wr_accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            commit_done_q <= commit_done_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(rd_addr) == i) begin
                rd_data = stage_val[i];
            end
        end
    end

    assign pending     = (state_q == DIRTY);
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_ffd_sinc_bank.sv
// Directed bench for the staged enable-register bank. Two instances share
// one stimulus stream: dut_a (N=4, registered outputs) and dut_b (N=3,
// write-through), so address 3 is a live channel for one and out of range
// for the other.
module tb_ffd_sinc_bank;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        commit;
   logic        discard;
   logic [1:0]  rd_addr;

   logic [7:0]  rd_a, rd_b;
   logic [31:0] q_a;
   logic [23:0] q_b;
   logic [3:0]  dirty_a;
   logic [2:0]  dirty_b;
   logic        pend_a, pend_b;
   logic        cd_a, cd_b;

   int nCompared;
   int nMismatched;

   ffd_sinc_bank #(.W(8), .N(4), .RESET_VAL(8'h00), .WRITE_THROUGH(1'b0)) dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .discard(discard), .rd_addr(rd_addr), .rd_data(rd_a),
      .q_flat(q_a), .dirty(dirty_a), .pending(pend_a), .commit_done(cd_a)
   );

   ffd_sinc_bank #(.W(8), .N(3), .RESET_VAL(8'h00), .WRITE_THROUGH(1'b1)) dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .discard(discard), .rd_addr(rd_addr), .rd_data(rd_b),
      .q_flat(q_b), .dirty(dirty_b), .pending(pend_b), .commit_done(cd_b)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] data,
                                input logic cm, input logic dc);
      wr_en   = we;
      wr_addr = addr;
      wr_data = data;
      commit  = cm;
      discard = dc;
      #1;
   endtask

   // Advance past the next rising edge and return inputs to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      commit  = 1'b0;
      discard = 1'b0;
   endtask

   task automatic readBoth(input logic [1:0] addr);
      rd_addr = addr;
      #1;
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      int pulses;
      nCompared   = 0;
      nMismatched = 0;
      reset   = 1'b1;
      rd_addr = 2'd0;
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;

      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cd_a || cd_b) pulses++;
      end
      checkOutput("reset_q_a", q_a, 32'h0);
      checkOutput("reset_q_b", {8'h0, q_b}, 32'h0);
      checkOutput("reset_dirty", {24'h0, dirty_a, 1'b0, dirty_b}, 32'h0);
      checkOutput("reset_pending", {30'h0, pend_a, pend_b}, 32'h0);
      checkOutput("reset_no_pulse", pulses, 32'd0);

      // Stage ch1 and ch3, then commit.
      applyStimulus(1'b1, 2'd1, 8'h23, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 2'd3, 8'h59, 1'b0, 1'b0);
      tick();
      checkOutput("staged_dirty_a", {28'h0, dirty_a}, 32'h0000000A);
      checkOutput("staged_dirty_b", {29'h0, dirty_b}, 32'h00000002);
      checkOutput("staged_q_a", q_a, 32'h0);
      checkOutput("staged_pending", {30'h0, pend_a, pend_b}, 32'h3);
      readBoth(2'd3);
      checkOutput("rd3_a", {24'h0, rd_a}, 32'h59);
      checkOutput("rd3_b_oor", {24'h0, rd_b}, 32'h0);

      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      checkOutput("commit_cycle_q_a", q_a, 32'h0);
      checkOutput("commit_cycle_q_b_wt", {8'h0, q_b}, 32'h00002300);
      tick();
      checkOutput("commit_q_a", q_a, 32'h59002300);
      checkOutput("commit_q_b", {8'h0, q_b}, 32'h00002300);
      checkOutput("commit_done", {30'h0, cd_a, cd_b}, 32'h3);
      checkOutput("commit_dirty_a", {28'h0, dirty_a}, 32'h0);
      tick();
      checkOutput("commit_done_one_cycle", {30'h0, cd_a, cd_b}, 32'h0);

      // Write merged with commit.
      applyStimulus(1'b1, 2'd0, 8'h12, 1'b1, 1'b0);
      checkOutput("merge_cycle_q_a", q_a, 32'h59002300);
      checkOutput("merge_cycle_q_b_wt", {8'h0, q_b}, 32'h00002312);
      tick();
      checkOutput("merge_q_a", q_a, 32'h59002312);
      checkOutput("merge_q_b", {8'h0, q_b}, 32'h00002312);
      checkOutput("merge_pending", {30'h0, pend_a, pend_b}, 32'h0);
      checkOutput("merge_done", {30'h0, cd_a, cd_b}, 32'h3);
      tick();

      // Stage ch2 then discard.
      applyStimulus(1'b1, 2'd2, 8'hAA, 1'b0, 1'b0);
      tick();
      readBoth(2'd2);
      checkOutput("stage2_rd_a", {24'h0, rd_a}, 32'hAA);
      checkOutput("stage2_dirty_a", {28'h0, dirty_a}, 32'h4);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
      tick();
      checkOutput("discard_rd_a", {24'h0, rd_a}, 32'h00);
      checkOutput("discard_rd_b", {24'h0, rd_b}, 32'h00);
      checkOutput("discard_dirty", {24'h0, dirty_a, 1'b0, dirty_b}, 32'h0);
      checkOutput("discard_no_pulse", {30'h0, cd_a, cd_b}, 32'h0);
      checkOutput("discard_q_a", q_a, 32'h59002312);

      // Write together with discard is dropped; earlier staging reverts.
      applyStimulus(1'b1, 2'd1, 8'h77, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 2'd2, 8'hBB, 1'b0, 1'b1);
      tick();
      readBoth(2'd2);
      checkOutput("wr_discard_rd2", {24'h0, rd_a}, 32'h00);
      readBoth(2'd1);
      checkOutput("wr_discard_rd1", {24'h0, rd_a}, 32'h23);
      checkOutput("wr_discard_pending", {30'h0, pend_a, pend_b}, 32'h0);

      // Commit while idle: nothing to move, no pulse.
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("idle_commit_no_pulse", {30'h0, cd_a, cd_b}, 32'h0);

      // Write to addr 3 merged with commit: real on dut_a, ignored on dut_b.
      applyStimulus(1'b1, 2'd3, 8'hC3, 1'b1, 1'b0);
      tick();
      checkOutput("oor_commit_q_a", q_a, 32'hC3002312);
      checkOutput("oor_commit_q_b", {8'h0, q_b}, 32'h00002312);
      checkOutput("oor_commit_pulse", {30'h0, cd_a, cd_b}, 32'h2);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("back_to_back_no_pulse", {30'h0, cd_a, cd_b}, 32'h0);

      // Commit + discard + write: commit wins, write merged.
      applyStimulus(1'b1, 2'd2, 8'h44, 1'b1, 1'b1);
      tick();
      checkOutput("cm_dc_q_a", q_a, 32'hC3442312);
      checkOutput("cm_dc_q_b", {8'h0, q_b}, 32'h00442312);
      checkOutput("cm_dc_pulse", {30'h0, cd_a, cd_b}, 32'h3);
      tick();

      // Reset in the commit cycle.
      applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_commit_q_a", q_a, 32'h0);
      checkOutput("rst_commit_q_b", {8'h0, q_b}, 32'h0);
      checkOutput("rst_commit_state", {24'h0, dirty_a, pend_a, pend_b, cd_a, cd_b}, 32'h0);
      tick();
      checkOutput("rst_commit_no_pulse", {30'h0, cd_a, cd_b}, 32'h0);
      readBoth(2'd0);
      checkOutput("rst_commit_rd0", {24'h0, rd_a}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
